z3_dma_burst_master: RTL and testbench

Parametrised Zorro III DMA bus master for the SCSI DMA path. Runs single or multiple-transfer (burst) Zorro III cycles after the arbiter grants the bus. Derives byte-lane strobes from 68030-style sizing. Adds DTACK timeout, BERR abort, transparent fallback to single cycles when the slave refuses bursts, and per-beat acknowledge to the SCSI side.

---
 rtl/z3_dma_burst_master.sv | 205 ++++++++++++++++++++
 tb/tb_z3_dma_burst_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z3_dma_burst_master.sv
// Zorro III DMA bus master for the SCSI DMA path: single and multiple-transfer cycles,
// byte-lane strobes from 68030 sizing, DTACK timeout, BERR abort and per-beat acknowledge.
module z3_dma_burst_master #(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned LW = $clog2(MAX_BURST + 1),
    localparam int unsigned TW = $clog2(TIMEOUT + 1)
) (
    input  logic          CLK,
    input  logic          RESET_n,
    input  logic          BMASTER,
    input  logic          REQ,
    input  logic          READ,
    input  logic [1:0]    SIZ,
    input  logic [1:0]    A,
    input  logic [LW-1:0] BURST_LEN,
    input  logic          ZORRO_DTACK_n,
    input  logic          ZORRO_MTACK_n,
    input  logic          ZORRO_BERR_n,
    output logic          DMA_FCS_n,
    output logic          DMA_MTCR_n,
    output logic [3:0]    DMA_DS_n,
    output logic          DMA_DOE,
    output logic          XFER_ACK,
    output logic          DONE,
    output logic          ERR,
    output logic          BUSY,
    output logic [LW-1:0] REMAIN
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StAck,
        StMnext,
        StEnd,
        StAbort
    } state_t;

    state_t        r_state;
    logic          r_read;
    logic [1:0]    r_siz;
    logic [1:0]    r_a;
    logic [LW-1:0] r_remain;
    logic          r_first;
    logic          r_mt_ok;
    logic [TW-1:0] r_cnt;
    logic          r_fcs_n;
    logic          r_mtcr_n;
    logic [3:0]    r_ds_n;
    logic          r_doe;
    logic          r_xfer_ack;
    logic          r_done;
    logic          r_err;
    logic          r_busy;

    logic [2:0]    w_size;
    logic [2:0]    w_last;
    logic [3:0]    w_first_ds_n;

    // First-beat lanes run from A up to A+size-1; lanes past offset 3 simply fall off.
    always_comb begin
        unique case (r_siz)
            2'b00:   w_size = 3'd4;
            2'b01:   w_size = 3'd1;
            2'b10:   w_size = 3'd2;
            default: w_size = 3'd3;
        endcase
        w_last       = {1'b0, r_a} + w_size - 3'd1;
        w_first_ds_n = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if ((3'(k) >= {1'b0, r_a}) && (3'(k) <= w_last)) begin
                w_first_ds_n[3-k] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= StIdle;
            r_read     <= 1'b0;
            r_siz      <= 2'b00;
            r_a        <= 2'b00;
            r_remain   <= '0;
            r_first    <= 1'b0;
            r_mt_ok    <= 1'b0;
            r_cnt      <= '0;
            r_fcs_n    <= 1'b1;
            r_mtcr_n   <= 1'b1;
            r_ds_n     <= 4'hF;
            r_doe      <= 1'b0;
            r_xfer_ack <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_xfer_ack <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (BMASTER && REQ && (BURST_LEN != '0)) begin
                        r_read   <= READ;
                        r_siz    <= SIZ;
                        r_a      <= A;
                        r_remain <= BURST_LEN;
                        r_first  <= 1'b1;
                        r_cnt    <= '0;
                        r_fcs_n  <= 1'b0;
                        r_mtcr_n <= !(BURST_LEN > LW'(1));
                        r_busy   <= 1'b1;
                        r_state  <= StAddr;
                    end
                end
                StAddr: begin
                    r_ds_n  <= (r_first && !r_read) ? w_first_ds_n : 4'h0;
                    r_doe   <= !r_read;
                    r_cnt   <= '0;
                    r_state <= StData;
                end
                StData: begin
                    if (!ZORRO_BERR_n) begin
                        r_fcs_n  <= 1'b1;
                        r_mtcr_n <= 1'b1;
                        r_ds_n   <= 4'hF;
                        r_doe    <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= StAbort;
                    end else if (!ZORRO_DTACK_n) begin
                        r_mt_ok    <= !ZORRO_MTACK_n;
                        r_xfer_ack <= 1'b1;
                        r_remain   <= r_remain - LW'(1);
                        r_state    <= StAck;
                    end else if (r_cnt == TW'(TIMEOUT - 1)) begin
                        r_fcs_n  <= 1'b1;
                        r_mtcr_n <= 1'b1;
                        r_ds_n   <= 4'hF;
                        r_doe    <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= StAbort;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                StAck: begin
                    // r_remain already holds the post-beat count here.
                    r_first  <= 1'b0;
                    r_cnt    <= '0;
                    r_mtcr_n <= 1'b1;
                    r_ds_n   <= 4'hF;
                    r_doe    <= 1'b0;
                    if ((r_remain == '0) || !r_mt_ok) begin
                        r_fcs_n <= 1'b1;
                        r_state <= StEnd;
                    end else begin
                        r_state <= StMnext;
                    end
                end
                StMnext: begin
                    if (ZORRO_DTACK_n) begin
                        r_mtcr_n <= 1'b0;
                        r_ds_n   <= 4'h0;
                        r_doe    <= !r_read;
                        r_cnt    <= '0;
                        r_state  <= StData;
                    end
                end
                StEnd: begin
                    if (ZORRO_DTACK_n) begin
                        if ((r_remain == '0) || !BMASTER) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end else begin
                            r_fcs_n  <= 1'b0;
                            r_mtcr_n <= !(r_remain > LW'(1));
                            r_state  <= StAddr;
                        end
                    end
                end
                StAbort: begin
                    if (ZORRO_DTACK_n && ZORRO_BERR_n) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign DMA_FCS_n  = r_fcs_n;
    assign DMA_MTCR_n = r_mtcr_n;
    assign DMA_DS_n   = r_ds_n;
    assign DMA_DOE    = r_doe;
    assign XFER_ACK   = r_xfer_ack;
    assign DONE       = r_done;
    assign ERR        = r_err;
    assign BUSY       = r_busy;
    assign REMAIN     = r_remain;

endmodule

// File: tb/tb_z3_dma_burst_master.sv
// Directed bench for z3_dma_burst_master: lane decoding, bursts, refused bursts,
// timeout, BERR, grant loss and asynchronous reset.
module tb_z3_dma_burst_master;

    logic       CLK;
    logic       RESET_n;
    logic       BMASTER;
    logic       REQ;
    logic       READ;
    logic [1:0] SIZ;
    logic [1:0] A;
    logic [3:0] BURST_LEN;
    logic       ZORRO_DTACK_n;
    logic       ZORRO_MTACK_n;
    logic       ZORRO_BERR_n;
    logic       DMA_FCS_n;
    logic       DMA_MTCR_n;
    logic [3:0] DMA_DS_n;
    logic       DMA_DOE;
    logic       XFER_ACK;
    logic       DONE;
    logic       ERR;
    logic       BUSY;
    logic [3:0] REMAIN;

    int n_checks = 0;
    int n_errors = 0;

    z3_dma_burst_master #(
        .MAX_BURST(8),
        .TIMEOUT  (255)
    ) u_dut (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .BMASTER      (BMASTER),
        .REQ          (REQ),
        .READ         (READ),
        .SIZ          (SIZ),
        .A            (A),
        .BURST_LEN    (BURST_LEN),
        .ZORRO_DTACK_n(ZORRO_DTACK_n),
        .ZORRO_MTACK_n(ZORRO_MTACK_n),
        .ZORRO_BERR_n (ZORRO_BERR_n),
        .DMA_FCS_n    (DMA_FCS_n),
        .DMA_MTCR_n   (DMA_MTCR_n),
        .DMA_DS_n     (DMA_DS_n),
        .DMA_DOE      (DMA_DOE),
        .XFER_ACK     (XFER_ACK),
        .DONE         (DONE),
        .ERR          (ERR),
        .BUSY         (BUSY),
        .REMAIN       (REMAIN)
    );

    initial CLK = 1'b0;
    always #20 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic rd, input logic [1:0] siz, input logic [1:0] a,
                         input logic [3:0] len);
        BMASTER   = 1'b1;
        READ      = rd;
        SIZ       = siz;
        A         = a;
        BURST_LEN = len;
        REQ       = 1'b1;
        tick();
        REQ = 1'b0;
    endtask

    // One complete single-beat cycle; DTACK asserted after 'wait_cyc' DATA cycles.
    task automatic run_single(input string tag, input logic rd, input logic [1:0] siz,
                              input logic [1:0] a, input logic [3:0] exp_ds, input int wait_cyc);
        start(rd, siz, a, 4'd1);
        chk({tag, "_addr_fcs"}, 32'(DMA_FCS_n), 32'd0);
        chk({tag, "_addr_mtcr"}, 32'(DMA_MTCR_n), 32'd1);
        chk({tag, "_addr_busy"}, 32'(BUSY), 32'd1);
        tick();
        chk({tag, "_ds"}, 32'(DMA_DS_n), 32'(exp_ds));
        chk({tag, "_doe"}, 32'(DMA_DOE), 32'(!rd));
        for (int i = 1; i < wait_cyc; i++) tick();
        ZORRO_DTACK_n = 1'b0;
        tick();
        chk({tag, "_xack"}, 32'(XFER_ACK), 32'd1);
        chk({tag, "_remain"}, 32'(REMAIN), 32'd0);
        ZORRO_DTACK_n = 1'b1;
        tick();
        chk({tag, "_end_xack"}, 32'(XFER_ACK), 32'd0);
        chk({tag, "_end_fcs"}, 32'(DMA_FCS_n), 32'd1);
        chk({tag, "_end_ds"}, 32'(DMA_DS_n), 32'hF);
        tick();
        chk({tag, "_done"}, 32'(DONE), 32'd1);
        chk({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        RESET_n       = 1'b0;
        BMASTER       = 1'b0;
        REQ           = 1'b0;
        READ          = 1'b0;
        SIZ           = 2'b00;
        A             = 2'b00;
        BURST_LEN     = 4'd0;
        ZORRO_DTACK_n = 1'b1;
        ZORRO_MTACK_n = 1'b1;
        ZORRO_BERR_n  = 1'b1;
        repeat (3) tick();
        chk("rst_fcs", 32'(DMA_FCS_n), 32'd1);
        chk("rst_mtcr", 32'(DMA_MTCR_n), 32'd1);
        chk("rst_ds", 32'(DMA_DS_n), 32'hF);
        chk("rst_doe", 32'(DMA_DOE), 32'd0);
        chk("rst_flags", 32'({XFER_ACK, DONE, ERR, BUSY}), 32'd0);
        chk("rst_remain", 32'(REMAIN), 32'd0);
        RESET_n = 1'b1;
        tick();

        // Zero-length request is ignored.
        start(1'b0, 2'b00, 2'b00, 4'd0);
        chk("len0_busy", 32'(BUSY), 32'd0);
        chk("len0_fcs", 32'(DMA_FCS_n), 32'd1);

        run_single("long_a0", 1'b0, 2'b00, 2'd0, 4'b0000, 2);
        run_single("byte_a2", 1'b0, 2'b01, 2'd2, 4'b1101, 1);
        run_single("word_a3", 1'b0, 2'b10, 2'd3, 4'b1110, 1);
        run_single("tri_a1", 1'b0, 2'b11, 2'd1, 4'b1000, 1);
        run_single("word_a1", 1'b0, 2'b10, 2'd1, 4'b1001, 1);
        run_single("read_byte", 1'b1, 2'b01, 2'd2, 4'b0000, 1);

        // Accepted burst of 4: FCS stays low, MTCR toggles each beat.
        start(1'b0, 2'b00, 2'd0, 4'd4);
        chk("b4_addr_mtcr", 32'(DMA_MTCR_n), 32'd0);
        tick();
        chk("b4_data0_mtcr", 32'(DMA_MTCR_n), 32'd0);
        for (int b = 0; b < 4; b++) begin
            ZORRO_DTACK_n = 1'b0;
            ZORRO_MTACK_n = 1'b0;
            tick();
            chk($sformatf("b4_ack%0d_xack", b), 32'(XFER_ACK), 32'd1);
            chk($sformatf("b4_ack%0d_remain", b), 32'(REMAIN), 32'(3 - b));
            chk($sformatf("b4_ack%0d_fcs", b), 32'(DMA_FCS_n), 32'd0);
            ZORRO_DTACK_n = 1'b1;
            ZORRO_MTACK_n = 1'b1;
            tick();
            if (b < 3) begin
                chk($sformatf("b4_mnext%0d_mtcr", b), 32'(DMA_MTCR_n), 32'd1);
                chk($sformatf("b4_mnext%0d_fcs", b), 32'(DMA_FCS_n), 32'd0);
                chk($sformatf("b4_mnext%0d_ds", b), 32'(DMA_DS_n), 32'hF);
                chk($sformatf("b4_mnext%0d_done", b), 32'(DONE), 32'd0);
                tick();
                chk($sformatf("b4_data%0d_mtcr", b + 1), 32'(DMA_MTCR_n), 32'd0);
                chk($sformatf("b4_data%0d_fcs", b + 1), 32'(DMA_FCS_n), 32'd0);
                chk($sformatf("b4_data%0d_ds", b + 1), 32'(DMA_DS_n), 32'h0);
            end else begin
                chk("b4_end_fcs", 32'(DMA_FCS_n), 32'd1);
                chk("b4_end_done", 32'(DONE), 32'd0);
                tick();
                chk("b4_done", 32'(DONE), 32'd1);
                chk("b4_busy", 32'(BUSY), 32'd0);
            end
        end
        tick();
        chk("b4_done_once", 32'(DONE), 32'd0);

        // Refused burst of 3: each beat becomes its own full cycle; later beats use all lanes.
        start(1'b0, 2'b01, 2'd2, 4'd3);
        chk("r3_addr_mtcr", 32'(DMA_MTCR_n), 32'd0);
        tick();
        chk("r3_data0_ds", 32'(DMA_DS_n), 32'b1101);
        for (int b = 0; b < 3; b++) begin
            ZORRO_DTACK_n = 1'b0;
            tick();
            chk($sformatf("r3_ack%0d_xack", b), 32'(XFER_ACK), 32'd1);
            chk($sformatf("r3_ack%0d_remain", b), 32'(REMAIN), 32'(2 - b));
            ZORRO_DTACK_n = 1'b1;
            tick();
            chk($sformatf("r3_end%0d_fcs", b), 32'(DMA_FCS_n), 32'd1);
            chk($sformatf("r3_end%0d_mtcr", b), 32'(DMA_MTCR_n), 32'd1);
            tick();
            if (b < 2) begin
                chk($sformatf("r3_readdr%0d_fcs", b), 32'(DMA_FCS_n), 32'd0);
                chk($sformatf("r3_readdr%0d_mtcr", b), 32'(DMA_MTCR_n), 32'(b == 1));
                chk($sformatf("r3_readdr%0d_done", b), 32'(DONE), 32'd0);
                tick();
                chk($sformatf("r3_data%0d_ds", b + 1), 32'(DMA_DS_n), 32'h0);
            end else begin
                chk("r3_done", 32'(DONE), 32'd1);
                chk("r3_busy", 32'(BUSY), 32'd0);
            end
        end

        // DTACK never arrives: ERR exactly 255 cycles after DATA entry.
        start(1'b0, 2'b00, 2'd0, 4'd2);
        tick();
        repeat (254) tick();
        chk("to_254_err", 32'(ERR), 32'd0);
        chk("to_254_fcs", 32'(DMA_FCS_n), 32'd0);
        tick();
        chk("to_255_err", 32'(ERR), 32'd1);
        chk("to_255_fcs", 32'(DMA_FCS_n), 32'd1);
        chk("to_255_remain", 32'(REMAIN), 32'd2);
        tick();
        chk("to_err_pulse", 32'(ERR), 32'd0);
        chk("to_idle_busy", 32'(BUSY), 32'd0);
        chk("to_no_done", 32'(DONE), 32'd0);
        chk("to_remain_held", 32'(REMAIN), 32'd2);

        // BERR and DTACK together: abort wins, no beat acknowledge.
        start(1'b0, 2'b00, 2'd0, 4'd1);
        tick();
        ZORRO_BERR_n  = 1'b0;
        ZORRO_DTACK_n = 1'b0;
        tick();
        chk("berr_err", 32'(ERR), 32'd1);
        chk("berr_xack", 32'(XFER_ACK), 32'd0);
        chk("berr_remain", 32'(REMAIN), 32'd1);
        tick();
        chk("berr_hold_busy", 32'(BUSY), 32'd1);
        chk("berr_hold_err", 32'(ERR), 32'd0);
        ZORRO_BERR_n  = 1'b1;
        ZORRO_DTACK_n = 1'b1;
        tick();
        chk("berr_idle_busy", 32'(BUSY), 32'd0);

        // Grant lost during beat 2 of 4: beat completes, then back to IDLE.
        start(1'b0, 2'b00, 2'd0, 4'd4);
        tick();
        ZORRO_DTACK_n = 1'b0;
        tick();
        chk("gl_ack1_remain", 32'(REMAIN), 32'd3);
        ZORRO_DTACK_n = 1'b1;
        tick();
        tick();
        chk("gl_readdr_fcs", 32'(DMA_FCS_n), 32'd0);
        tick();
        BMASTER       = 1'b0;
        ZORRO_DTACK_n = 1'b0;
        tick();
        chk("gl_ack2_xack", 32'(XFER_ACK), 32'd1);
        chk("gl_ack2_remain", 32'(REMAIN), 32'd2);
        ZORRO_DTACK_n = 1'b1;
        tick();
        tick();
        chk("gl_done", 32'(DONE), 32'd1);
        chk("gl_busy", 32'(BUSY), 32'd0);
        chk("gl_remain", 32'(REMAIN), 32'd2);

        // Asynchronous reset in the middle of DATA.
        start(1'b0, 2'b00, 2'd0, 4'd2);
        tick();
        chk("ar_pre_fcs", 32'(DMA_FCS_n), 32'd0);
        #2 RESET_n = 1'b0;
        #1;
        chk("ar_fcs", 32'(DMA_FCS_n), 32'd1);
        chk("ar_mtcr", 32'(DMA_MTCR_n), 32'd1);
        chk("ar_ds", 32'(DMA_DS_n), 32'hF);
        chk("ar_doe", 32'(DMA_DOE), 32'd0);
        chk("ar_busy", 32'(BUSY), 32'd0);
        chk("ar_remain", 32'(REMAIN), 32'd0);
        tick();
        RESET_n = 1'b1;
        tick();
        chk("ar_after_busy", 32'(BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
